dma_arbiter18: RTL and testbench

DMA_ARBITER18 -- requirements
Module: dma_arbiter18

---
 rtl/dma_arbiter18.sv | 163 ++++++++++++++++
 tb/tb_dma_arbiter18.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter18.sv
// Two-channel round-robin DMA arbiter muxing channel requests onto the CPU board's 18-bit bus.
// Optional transfer timeout/abort logic is enabled by defining DMA_ARB_TIMEOUT_EN.
module dma_arbiter18 #(
  parameter int unsigned HOLD_MAX       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_p,
  input  logic        dclo,
  input  logic        ch0_req,
  input  logic [17:0] ch0_adr,
  input  logic        ch0_stb,
  input  logic        ch0_we,
  input  logic [1:0]  ch0_sel,
  input  logic [15:0] ch0_dat,
  output logic        ch0_gnt,
  output logic        ch0_ack,
  output logic        ch0_err,
  input  logic        ch1_req,
  input  logic [17:0] ch1_adr,
  input  logic        ch1_stb,
  input  logic        ch1_we,
  input  logic [1:0]  ch1_sel,
  input  logic [15:0] ch1_dat,
  output logic        ch1_gnt,
  output logic        ch1_ack,
  output logic        ch1_err,
  output logic        dma_req,
  input  logic        dma_ack,
  output logic [17:0] dma_adr18,
  output logic        dma_stb,
  output logic        dma_we,
  output logic [1:0]  dma_sel,
  output logic [15:0] dma_dat,
  input  logic        global_ack
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  localparam logic [8:0] HOLD_LIM = 9'(HOLD_MAX);

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        last, last_nx;
  logic [7:0]  xfer_cnt, xfer_cnt_nx;
  logic [1:0]  err;
  logic [1:0]  elig;
  logic        granted, own_req, own_stb, ack, tmo;

  always_comb begin
    granted = (state == GRANT);
    own_req = owner ? ch1_req : ch0_req;
    own_stb = owner ? ch1_stb : ch0_stb;
    dma_req = (state == REQ) || granted;
    dma_stb = granted & own_stb;
    // ack is withheld once the bus is lost or while reset is being applied
    ack     = dma_stb & global_ack & dma_ack & ~dclo;
    ch0_gnt = granted & ~owner;
    ch1_gnt = granted & owner;
    ch0_ack = ack & ~owner;
    ch1_ack = ack & owner;
    ch0_err = err[0];
    ch1_err = err[1];
    dma_adr18 = '0;
    dma_we    = 1'b0;
    dma_sel   = '0;
    dma_dat   = '0;
    if (granted) begin
      dma_adr18 = owner ? ch1_adr : ch0_adr;
      dma_we    = owner ? ch1_we  : ch0_we;
      dma_sel   = owner ? ch1_sel : ch0_sel;
      dma_dat   = owner ? ch1_dat : ch0_dat;
    end
    elig = {ch1_req, ch0_req} & ~err;
  end

`ifdef DMA_ARB_TIMEOUT_EN
  localparam logic [8:0] TMO_LIM = 9'(TIMEOUT_CYCLES);

  logic [7:0] tcnt, tcnt_nx;
  logic [1:0] err_nx;
  logic       stall;

  always_comb begin
    stall   = granted & dma_stb & ~global_ack;
    tcnt_nx = stall ? tcnt + 8'd1 : '0;
    tmo     = stall & (({1'b0, tcnt} + 9'd1) == TMO_LIM);
    err_nx  = err;
    for (int unsigned i = 0; i < 2; i++) begin
      if (tmo && (owner == 1'(i)))
        err_nx[i] = 1'b1;
      else if (!(i == 0 ? ch0_req : ch1_req))
        err_nx[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      tcnt <= '0;
      err  <= '0;
    end else begin
      tcnt <= tcnt_nx;
      err  <= err_nx;
    end
  end
`else
  always_comb begin
    tmo = 1'b0;
    err = '0;
  end
`endif

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_nx     = last;
    xfer_cnt_nx = xfer_cnt;
    unique case (state)
      IDLE: begin
        xfer_cnt_nx = '0;
        if (|elig) begin
          owner_nx = (elig == 2'b11) ? ~last : elig[1];
          state_nx = REQ;
        end
      end
      REQ: begin
        if (dma_ack) state_nx = GRANT;
      end
      GRANT: begin
        xfer_cnt_nx = xfer_cnt + 8'(ack);
        if (!dma_ack)
          state_nx = RELEASE;
        else if (ack && (({1'b0, xfer_cnt} + 9'd1) >= HOLD_LIM))
          state_nx = RELEASE;
        else if (tmo)
          state_nx = RELEASE;
        else if (!own_req && !own_stb)
          state_nx = RELEASE;
      end
      RELEASE: begin
        if (!dma_ack) begin
          state_nx = IDLE;
          last_nx  = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (dclo) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      xfer_cnt <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last     <= last_nx;
      xfer_cnt <= xfer_cnt_nx;
    end
  end

endmodule

// File: tb/tb_dma_arbiter18.sv
// Directed/randomized bench for dma_arbiter18 (HOLD_MAX=4, TIMEOUT_CYCLES=8).
module tb_dma_arbiter18;
  localparam int HOLD = 4;

  logic        clk_p = 1'b0;
  logic        dclo = 1'b1;
  logic [1:0]  req_v = '0, stb_v = '0, we_v = '0;
  logic [17:0] adr_v [2];
  logic [1:0]  sel_v [2];
  logic [15:0] dat_v [2];
  logic        dma_ack = 1'b0, global_ack = 1'b0;
  logic        ch0_gnt, ch0_ack, ch0_err, ch1_gnt, ch1_ack, ch1_err;
  logic        dma_req, dma_stb, dma_we;
  logic [17:0] dma_adr18;
  logic [1:0]  dma_sel;
  logic [15:0] dma_dat;
  int total = 0, bad = 0;

  always #5 clk_p = ~clk_p;

  dma_arbiter18 #(.HOLD_MAX(HOLD), .TIMEOUT_CYCLES(8)) dut (
    .clk_p(clk_p), .dclo(dclo),
    .ch0_req(req_v[0]), .ch0_adr(adr_v[0]), .ch0_stb(stb_v[0]), .ch0_we(we_v[0]),
    .ch0_sel(sel_v[0]), .ch0_dat(dat_v[0]), .ch0_gnt(ch0_gnt), .ch0_ack(ch0_ack), .ch0_err(ch0_err),
    .ch1_req(req_v[1]), .ch1_adr(adr_v[1]), .ch1_stb(stb_v[1]), .ch1_we(we_v[1]),
    .ch1_sel(sel_v[1]), .ch1_dat(dat_v[1]), .ch1_gnt(ch1_gnt), .ch1_ack(ch1_ack), .ch1_err(ch1_err),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_adr18(dma_adr18), .dma_stb(dma_stb),
    .dma_we(dma_we), .dma_sel(dma_sel), .dma_dat(dma_dat), .global_ack(global_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_p);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return 64'({dma_req, dma_stb, dma_we, dma_sel, dma_adr18, dma_dat,
                ch1_gnt, ch0_gnt, ch1_ack, ch0_ack});
  endfunction

  // From IDLE with requests set: expect REQ, answer dma_ack two cycles after the request, expect the grant.
  task automatic arbitrate(input int ch);
    cyc();
    chk("req_phase", {dma_req, ch1_gnt, ch0_gnt}, 3'b100);
    cyc();
    dma_ack = 1'b1;
    cyc();
    chk($sformatf("grant_ch%0d", ch), {ch1_gnt, ch0_gnt}, (ch == 1) ? 2'b10 : 2'b01);
  endtask

  // One owner transfer with random data and wait states; the bus must mirror the owner.
  task automatic xfer(input int ch, input int waits, inout int acks);
    for (int i = 0; i < 2; i++) begin
      adr_v[i] = 18'($urandom);
      dat_v[i] = 16'($urandom);
      sel_v[i] = 2'($urandom);
      we_v[i]  = 1'($urandom);
    end
    stb_v[ch] = 1'b1;
    for (int w = 0; w <= waits; w++) begin
      global_ack = (w == waits);
      #1;
      chk("bus_mux", {dma_stb, dma_we, dma_sel, dma_adr18, dma_dat},
          {1'b1, we_v[ch], sel_v[ch], adr_v[ch], dat_v[ch]});
      chk("ack", {ch1_ack, ch0_ack}, global_ack ? ((ch == 1) ? 2'b10 : 2'b01) : 2'b00);
      if (ch1_ack | ch0_ack) acks++;
      cyc();
    end
    stb_v[ch] = 1'b0;
    global_ack = 1'b0;
  endtask

  task automatic end_burst(input int ch);
    req_v[ch] = 1'b0;
    stb_v[ch] = 1'b0;
    #1;
    chk("still_granted", dma_req, 1'b1);
    cyc();
    chk("release_after_drop", {dma_req, ch1_gnt, ch0_gnt}, 3'b000);
    dma_ack = 1'b0;
    cyc();
    chk("idle_after_release", dma_req, 1'b0);
  endtask

  task automatic do_reset();
    dclo = 1'b1; req_v = '0; stb_v = '0; dma_ack = 1'b0; global_ack = 1'b0;
    cyc();
    cyc();
    dclo = 1'b0;
  endtask

  initial begin
    int acks, n, rem, b;
    for (int i = 0; i < 2; i++) begin
      adr_v[i] = '0; sel_v[i] = '0; dat_v[i] = '0;
    end

    // Reset state
    do_reset();
    chk("reset_outs", outs(), 64'd0);
    chk("reset_err", {ch1_err, ch0_err}, 2'b00);

    // Single-channel bursts; first has exactly 3 transfers
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 3 : int'($urandom_range(1, HOLD - 1));
      acks = 0;
      req_v[0] = 1'b1;
      arbitrate(0);
      for (int k = 0; k < n; k++) xfer(0, int'($urandom_range(0, 2)), acks);
      chk("ch0_ack_count", acks, n);
      end_burst(0);
    end

    // Simultaneous requests after reset, then bus loss mid-strobe
    do_reset();
    req_v = 2'b11;
    arbitrate(0);
    acks = 0;
    xfer(0, 0, acks);
    stb_v[0] = 1'b1; global_ack = 1'b0; dma_ack = 1'b0;
    #1;
    chk("no_ack_on_loss", {ch1_ack, ch0_ack}, 2'b00);
    cyc();
    chk("lost_bus_release", {dma_req, dma_stb, ch1_gnt, ch0_gnt, ch1_ack, ch0_ack}, 6'd0);
    stb_v[0] = 1'b0;
    cyc();
    chk("lost_bus_idle", dma_req, 1'b0);
    arbitrate(1);
    xfer(1, 1, acks);
    end_burst(1);
    arbitrate(0);
    end_burst(0);

    // ch1 streams 10 transfers with ch0 pending: split into HOLD-sized grants
    req_v = 2'b11;
    rem = 10;
    acks = 0;
    arbitrate(1);
    while (rem > 0) begin
      b = (rem < HOLD) ? rem : HOLD;
      for (int k = 0; k < b; k++) xfer(1, 0, acks);
      rem -= b;
      if (b == HOLD) begin
        chk("hold_release", {dma_req, ch1_gnt, ch0_gnt}, 3'b000);
        dma_ack = 1'b0;
        cyc();
        if (req_v[0]) begin
          arbitrate(0);
          xfer(0, 0, n);
          end_burst(0);
        end
        if (rem > 0) arbitrate(1);
        else begin
          req_v[1] = 1'b0;
          cyc();
        end
      end else begin
        end_burst(1);
      end
    end
    chk("ch1_total_acks", acks, 10);

`ifdef DMA_ARB_TIMEOUT_EN
    req_v[0] = 1'b1;
    arbitrate(0);
    stb_v[0] = 1'b1; global_ack = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("pre_timeout", {ch0_err, dma_req, ch0_ack}, 3'b010);
      cyc();
    end
    chk("timeout_abort", {ch0_err, dma_req, ch0_gnt}, 3'b100);
    dma_ack = 1'b0; stb_v[0] = 1'b0;
    cyc();
    cyc();
    chk("err_blocks_grant", dma_req, 1'b0);
    cyc();
    chk("err_held", {ch0_err, dma_req}, 2'b10);
    req_v[0] = 1'b0;
    cyc();
    chk("err_cleared", ch0_err, 1'b0);
`else
    req_v[0] = 1'b1;
    arbitrate(0);
    stb_v[0] = 1'b1; global_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("held_no_timeout", {ch0_err, ch1_err, dma_req, ch0_gnt, ch0_ack}, 5'b00110);
      cyc();
    end
    global_ack = 1'b1;
    #1;
    chk("late_ack", ch0_ack, 1'b1);
    cyc();
    global_ack = 1'b0;
    end_burst(0);
`endif

    // Reset coinciding with an ack during GRANT
    req_v[1] = 1'b1;
    arbitrate(1);
    stb_v[1] = 1'b1; global_ack = 1'b1; dclo = 1'b1;
    #1;
    chk("no_ack_in_reset", {ch1_ack, ch0_ack}, 2'b00);
    cyc();
    chk("outs_after_reset", outs(), 64'd0);
    dclo = 1'b0; req_v = '0; stb_v = '0; global_ack = 1'b0; dma_ack = 1'b0;
    cyc();
    chk("idle_after_reset", {outs(), ch1_err, ch0_err}, 66'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
